id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding for the 5-stage MIPS core.
- Captures decoded instruction fields at the end of ID.
- During EX, drives the ALU's ALUCode, A and B inputs, and the store data, using forwarded values from MEM and WB.
- Generates the load-use stall and performs branch flush, so the ALU always sees correct operands or a bubble.

Parameters:
- DW, 32, datapath width
- RW, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_ALUCode  in  4  ALU operation (add=0000 … sltu=1010)
- id_ALUSrcA  in  2  A source: 00 rs1, 01 PC, 10 zero, 11 reserved (treated as zero)
- id_ALUSrcB  in  1  B source: 0 rs2, 1 immediate
- id_rs1Addr, id_rs2Addr, id_rdAddr  in  RW each  register addresses
- id_rs1Data, id_rs2Data  in  DW each  register-file read data
- id_imm, id_PC  in  DW each  extended immediate, instruction PC
- id_RegWrite, id_MemRead, id_MemWrite  in  1 each  control
- flush  in  1  taken branch/jump resolved in EX; kill ID instruction
- mem_RegWrite  in  1  MEM-stage write enable
- mem_rdAddr  in  RW  MEM-stage destination
- mem_ALUResult  in  DW  MEM-stage forward value
- wb_RegWrite  in  1  WB-stage write enable
- wb_rdAddr  in  RW  WB-stage destination
- wb_Data  in  DW  WB-stage forward value
- stall  out  1  hold PC and IF/ID (combinational)
- ALUCode  out  4  to ALU
- A, B  out  DW  to ALU operands
- ex_StoreData  out  DW  forwarded rs2 for stores
- ex_rdAddr  out  RW  registered destination
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_valid  out  1 each  registered control

Behaviour:
- Reset (sync, clk edge with reset=1): all registered fields to 0. Outputs ALUCode=0000 (add), A=B=0, ex_* = 0, stall=0.
- Latency: one cycle. ID fields presented in cycle n appear at the EX outputs in cycle n+1.
- Uses-rs1 = (id_ALUSrcA==00).
- Uses-rs2 = (id_ALUSrcB==0) | id_MemWrite.
- stall = id_valid & ex_valid & ex_MemRead & ex_rdAddr!=0 & ((uses-rs1 & id_rs1Addr==ex_rdAddr) | (uses-rs2 & id_rs2Addr==ex_rdAddr)).
- Register update priority: reset > flush > stall > load.
  - flush or stall: load a bubble. valid, RegWrite, MemRead and MemWrite = 0; ALUCode=0000; data and addresses = 0.
  - Otherwise: load all id_* fields.
- flush and stall together: bubble once. Stall deasserts next cycle because ex_MemRead is then 0.
- Write-through on capture: if wb_RegWrite & wb_rdAddr!=0 & wb_rdAddr==id_rsXAddr, capture wb_Data instead of id_rsXData. Applies to each of rs1 and rs2 independently.
- EX forwarding (combinational on registered rs1/rs2 data; rsX stands for rs1 or rs2), highest priority first:
  - mem_RegWrite & mem_rdAddr!=0 & mem_rdAddr==ex_rsXAddr → mem_ALUResult
  - wb_RegWrite & wb_rdAddr!=0 & wb_rdAddr==ex_rsXAddr → wb_Data
  - else → captured data
  - Register 0 is never forwarded.
- A = fwd_rs1, registered PC or 0, per registered ALUSrcA.
- B = fwd_rs2 when ALUSrcB=0, else registered imm.
- ex_StoreData = fwd_rs2 regardless of ALUSrcB.
- All arithmetic is width-exact; no extension is performed here.
- ex_valid=0 has no effect on A/B values; downstream gates writes with ex_RegWrite/ex_MemWrite.
- Reset asserted mid-stall clears the register. Stall drops the following cycle.

Test Plan:
- Reset: reset=1 for 2 cycles with random inputs → ALUCode=0, A=B=0, all ex_* and stall = 0.
- Pass-through: add rs1=x1 (0x5), rs2=x2 (0x7), no hazards → next cycle ALUCode=0000, A=0x5, B=0x7. Also lui, imm=0x12345000, ALUSrcB=1 → B=0x12345000.
- Forwarding: EX has rs1=x3. Case 1: mem_rdAddr=3, mem_ALUResult=0xAAAA, wb_rdAddr=3, wb_Data=0xBBBB → A=0xAAAA (MEM priority). Case 2: mem_RegWrite=0 → A=0xBBBB. Case 3: rdAddr=0 with RegWrite=1 → A keeps captured value.
- Load-use: lw x4 in EX, ID `add x5,x4,x1` → stall=1 for exactly one cycle, EX gets bubble (ex_valid=0). Next cycle the add enters with A=forwarded WB load data. Same case with ID using x4 only via PC/imm → stall=0.
- Flush: flush=1 while id_valid=1 and stall=1 → next cycle ex_RegWrite=ex_MemWrite=ex_valid=0, stall=0.
- Write-through: wb writes x6=0xDEAD while ID reads x6 (id_rs1Data stale 0x0) → captured A=0xDEAD.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, load-use stall
// detection and branch flush for the 5-stage MIPS core.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [3:0]    id_ALUCode,
    input  logic [1:0]    id_ALUSrcA,
    input  logic          id_ALUSrcB,
    input  logic [RW-1:0] id_rs1Addr,
    input  logic [RW-1:0] id_rs2Addr,
    input  logic [RW-1:0] id_rdAddr,
    input  logic [DW-1:0] id_rs1Data,
    input  logic [DW-1:0] id_rs2Data,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_PC,
    input  logic          id_RegWrite,
    input  logic          id_MemRead,
    input  logic          id_MemWrite,
    input  logic          flush,
    input  logic          mem_RegWrite,
    input  logic [RW-1:0] mem_rdAddr,
    input  logic [DW-1:0] mem_ALUResult,
    input  logic          wb_RegWrite,
    input  logic [RW-1:0] wb_rdAddr,
    input  logic [DW-1:0] wb_Data,
    output logic          stall,
    output logic [3:0]    ALUCode,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [DW-1:0] ex_StoreData,
    output logic [RW-1:0] ex_rdAddr,
    output logic          ex_RegWrite,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_valid
);

    typedef struct packed {
        logic          valid;
        logic [3:0]    alu_code;
        logic [1:0]    src_a;
        logic          src_b;
        logic [RW-1:0] rs1_addr;
        logic [RW-1:0] rs2_addr;
        logic [RW-1:0] rd_addr;
        logic [DW-1:0] rs1_data;
        logic [DW-1:0] rs2_data;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } idex_t;

    idex_t ex_d, ex_q;

    logic          uses_rs1, uses_rs2;
    logic          stall_d;
    logic [DW-1:0] rs1_wt, rs2_wt;
    logic [DW-1:0] fwd_rs1, fwd_rs2;

    // Picks the freshest value of a source register; x0 is never overridden.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] addr,
        input logic [DW-1:0] captured,
        input logic          m_we,
        input logic [RW-1:0] m_rd,
        input logic [DW-1:0] m_val,
        input logic          w_we,
        input logic [RW-1:0] w_rd,
        input logic [DW-1:0] w_val
    );
        if (m_we && m_rd != '0 && m_rd == addr)
            return m_val;
        else if (w_we && w_rd != '0 && w_rd == addr)
            return w_val;
        else
            return captured;
    endfunction

    always_comb begin
        uses_rs1 = (id_ALUSrcA == 2'b00);
        uses_rs2 = !id_ALUSrcB || id_MemWrite;
        stall_d  = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                   ((uses_rs1 && id_rs1Addr == ex_q.rd_addr) ||
                    (uses_rs2 && id_rs2Addr == ex_q.rd_addr));
    end

    // The register file is read before WB writes it, so patch in WB's value at capture.
    always_comb begin
        rs1_wt = id_rs1Data;
        rs2_wt = id_rs2Data;
        if (wb_RegWrite && wb_rdAddr != '0 && wb_rdAddr == id_rs1Addr)
            rs1_wt = wb_Data;
        if (wb_RegWrite && wb_rdAddr != '0 && wb_rdAddr == id_rs2Addr)
            rs2_wt = wb_Data;
    end

    always_comb begin
        ex_d = '0;
        if (!(flush || stall_d)) begin
            ex_d.valid     = id_valid;
            ex_d.alu_code  = id_ALUCode;
            ex_d.src_a     = id_ALUSrcA;
            ex_d.src_b     = id_ALUSrcB;
            ex_d.rs1_addr  = id_rs1Addr;
            ex_d.rs2_addr  = id_rs2Addr;
            ex_d.rd_addr   = id_rdAddr;
            ex_d.rs1_data  = rs1_wt;
            ex_d.rs2_data  = rs2_wt;
            ex_d.imm       = id_imm;
            ex_d.pc        = id_PC;
            ex_d.reg_write = id_RegWrite;
            ex_d.mem_read  = id_MemRead;
            ex_d.mem_write = id_MemWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    always_comb begin
        fwd_rs1 = fwd_sel(ex_q.rs1_addr, ex_q.rs1_data, mem_RegWrite, mem_rdAddr,
                          mem_ALUResult, wb_RegWrite, wb_rdAddr, wb_Data);
        fwd_rs2 = fwd_sel(ex_q.rs2_addr, ex_q.rs2_data, mem_RegWrite, mem_rdAddr,
                          mem_ALUResult, wb_RegWrite, wb_rdAddr, wb_Data);
        case (ex_q.src_a)
            2'b00:   A = fwd_rs1;
            2'b01:   A = ex_q.pc;
            default: A = '0;
        endcase
        B = ex_q.src_b ? ex_q.imm : fwd_rs2;
    end

    assign stall        = stall_d;
    assign ALUCode      = ex_q.alu_code;
    assign ex_StoreData = fwd_rs2;
    assign ex_rdAddr    = ex_q.rd_addr;
    assign ex_RegWrite  = ex_q.reg_write;
    assign ex_MemRead   = ex_q.mem_read;
    assign ex_MemWrite  = ex_q.mem_write;
    assign ex_valid     = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, forwarding, load-use,
// flush, write-through and reset during a stall.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [3:0]    id_ALUCode;
    logic [1:0]    id_ALUSrcA;
    logic          id_ALUSrcB;
    logic [RW-1:0] id_rs1Addr, id_rs2Addr, id_rdAddr;
    logic [DW-1:0] id_rs1Data, id_rs2Data, id_imm, id_PC;
    logic          id_RegWrite, id_MemRead, id_MemWrite;
    logic          flush;
    logic          mem_RegWrite;
    logic [RW-1:0] mem_rdAddr;
    logic [DW-1:0] mem_ALUResult;
    logic          wb_RegWrite;
    logic [RW-1:0] wb_rdAddr;
    logic [DW-1:0] wb_Data;
    logic          stall;
    logic [3:0]    ALUCode;
    logic [DW-1:0] A, B, ex_StoreData;
    logic [RW-1:0] ex_rdAddr;
    logic          ex_RegWrite, ex_MemRead, ex_MemWrite, ex_valid;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUCode(id_ALUCode),
        .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB), .id_rs1Addr(id_rs1Addr),
        .id_rs2Addr(id_rs2Addr), .id_rdAddr(id_rdAddr), .id_rs1Data(id_rs1Data),
        .id_rs2Data(id_rs2Data), .id_imm(id_imm), .id_PC(id_PC),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .flush(flush), .mem_RegWrite(mem_RegWrite), .mem_rdAddr(mem_rdAddr),
        .mem_ALUResult(mem_ALUResult), .wb_RegWrite(wb_RegWrite), .wb_rdAddr(wb_rdAddr),
        .wb_Data(wb_Data), .stall(stall), .ALUCode(ALUCode), .A(A), .B(B),
        .ex_StoreData(ex_StoreData), .ex_rdAddr(ex_rdAddr), .ex_RegWrite(ex_RegWrite),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_valid = 0; id_ALUCode = 0; id_ALUSrcA = 0; id_ALUSrcB = 0;
        id_rs1Addr = 0; id_rs2Addr = 0; id_rdAddr = 0; id_rs1Data = 0; id_rs2Data = 0;
        id_imm = 0; id_PC = 0; id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0;
        flush = 0; mem_RegWrite = 0; mem_rdAddr = 0; mem_ALUResult = 0;
        wb_RegWrite = 0; wb_rdAddr = 0; wb_Data = 0;
    endtask

    task automatic set_id(input logic [3:0] code, input logic [1:0] sa, input logic sb,
                          input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                          input logic [RW-1:0] rd, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                          input logic [DW-1:0] pc, input logic rw, input logic mr,
                          input logic mw);
        id_valid = 1; id_ALUCode = code; id_ALUSrcA = sa; id_ALUSrcB = sb;
        id_rs1Addr = r1; id_rs2Addr = r2; id_rdAddr = rd; id_rs1Data = d1;
        id_rs2Data = d2; id_imm = imm; id_PC = pc;
        id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw;
    endtask

    task automatic test_reset();
        reset = 1;
        id_valid = 1; id_ALUCode = 4'($urandom); id_ALUSrcA = 2'($urandom);
        id_ALUSrcB = 1'($urandom); id_rs1Addr = 5'($urandom); id_rs2Addr = 5'($urandom);
        id_rdAddr = 5'($urandom); id_rs1Data = $urandom; id_rs2Data = $urandom;
        id_imm = $urandom; id_PC = $urandom; id_RegWrite = 1; id_MemRead = 1; id_MemWrite = 1;
        mem_RegWrite = 1; mem_rdAddr = 5'($urandom); mem_ALUResult = $urandom;
        wb_RegWrite = 1; wb_rdAddr = 5'($urandom); wb_Data = $urandom;
        tick();
        tick();
        total++; if (ALUCode !== 4'h0) begin bad++; $display("FAIL reset_alucode got=%h exp=0", ALUCode); end
        total++; if (A !== 32'h0) begin bad++; $display("FAIL reset_A got=%h exp=0", A); end
        total++; if (B !== 32'h0) begin bad++; $display("FAIL reset_B got=%h exp=0", B); end
        total++; if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite} !== 4'b0000 || ex_rdAddr !== 5'd0)
            begin bad++; $display("FAIL reset_ctrl got=%b/%0d exp=0000/0",
                {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite}, ex_rdAddr); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        reset = 0;
        clr_in();
        tick();
    endtask

    task automatic test_pass_through();
        // add x3, x1, x2
        set_id(4'h0, 2'b00, 1'b0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 32'h100, 1, 0, 0);
        tick();
        total++; if (ALUCode !== 4'h0) begin bad++; $display("FAIL add_alucode got=%h exp=0", ALUCode); end
        total++; if (A !== 32'h5) begin bad++; $display("FAIL add_A got=%h exp=5", A); end
        total++; if (B !== 32'h7) begin bad++; $display("FAIL add_B got=%h exp=7", B); end
        total++; if (ex_rdAddr !== 5'd3 || ex_RegWrite !== 1'b1 || ex_valid !== 1'b1)
            begin bad++; $display("FAIL add_ctrl got=rd%0d rw%b v%b exp=rd3 rw1 v1", ex_rdAddr, ex_RegWrite, ex_valid); end
        // lui: A from zero, B from immediate
        set_id(4'h9, 2'b10, 1'b1, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h12345000, 32'h104, 1, 0, 0);
        tick();
        total++; if (B !== 32'h12345000) begin bad++; $display("FAIL lui_B got=%h exp=12345000", B); end
        total++; if (A !== 32'h0 || ALUCode !== 4'h9) begin bad++; $display("FAIL lui_A got=%h/%h exp=0/9", A, ALUCode); end
        // PC as A source
        set_id(4'h0, 2'b01, 1'b1, 5'd1, 5'd0, 5'd8, 32'h55, 32'h0, 32'h8, 32'h400, 1, 0, 0);
        tick();
        total++; if (A !== 32'h400 || B !== 32'h8) begin bad++; $display("FAIL pc_src got=%h/%h exp=400/8", A, B); end
        // reserved A source reads as zero
        set_id(4'h0, 2'b11, 1'b0, 5'd1, 5'd2, 5'd8, 32'h55, 32'h66, 32'h8, 32'h400, 1, 0, 0);
        tick();
        total++; if (A !== 32'h0 || B !== 32'h66) begin bad++; $display("FAIL rsv_src got=%h/%h exp=0/66", A, B); end
        // sw x2, 8(x1): store data is rs2 even though B is the immediate
        set_id(4'h0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd0, 32'h1000, 32'hFEED, 32'h8, 32'h408, 0, 0, 1);
        tick();
        total++; if (ex_StoreData !== 32'hFEED || B !== 32'h8 || A !== 32'h1000 || ex_MemWrite !== 1'b1)
            begin bad++; $display("FAIL sw_data got=%h/%h/%h/%b exp=feed/8/1000/1", ex_StoreData, B, A, ex_MemWrite); end
        clr_in();
        tick();
    endtask

    task automatic test_forwarding();
        set_id(4'h0, 2'b00, 1'b0, 5'd3, 5'd3, 5'd9, 32'h1111, 32'h2222, 32'h0, 32'h0, 1, 0, 0);
        tick();
        clr_in();
        mem_RegWrite = 1; mem_rdAddr = 5'd3; mem_ALUResult = 32'hAAAA;
        wb_RegWrite = 1; wb_rdAddr = 5'd3; wb_Data = 32'hBBBB;
        #1;
        total++; if (A !== 32'hAAAA) begin bad++; $display("FAIL fwd_mem_A got=%h exp=aaaa", A); end
        total++; if (B !== 32'hAAAA || ex_StoreData !== 32'hAAAA)
            begin bad++; $display("FAIL fwd_mem_B got=%h/%h exp=aaaa/aaaa", B, ex_StoreData); end
        mem_RegWrite = 0;
        #1;
        total++; if (A !== 32'hBBBB) begin bad++; $display("FAIL fwd_wb_A got=%h exp=bbbb", A); end
        wb_RegWrite = 0;
        #1;
        total++; if (A !== 32'h1111 || B !== 32'h2222)
            begin bad++; $display("FAIL fwd_none got=%h/%h exp=1111/2222", A, B); end
        // destination x0 must never forward
        mem_RegWrite = 1; mem_rdAddr = 5'd0; wb_RegWrite = 1; wb_rdAddr = 5'd0;
        set_id(4'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd9, 32'h77, 32'h88, 32'h0, 32'h0, 1, 0, 0);
        tick();
        total++; if (A !== 32'h77 || B !== 32'h88)
            begin bad++; $display("FAIL fwd_x0 got=%h/%h exp=77/88", A, B); end
        clr_in();
        tick();
    endtask

    task automatic test_load_use();
        // lw x4, 4(x1)
        set_id(4'h0, 2'b00, 1'b1, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h4, 32'h200, 1, 1, 0);
        tick();
        // add x5, x4, x1 with stale x4
        set_id(4'h0, 2'b00, 1'b0, 5'd4, 5'd1, 5'd5, 32'h0, 32'h100, 32'h0, 32'h204, 1, 0, 0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
        tick();
        total++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_MemRead !== 1'b0 || stall !== 1'b0)
            begin bad++; $display("FAIL lu_bubble got=v%b rw%b mr%b st%b exp=0000", ex_valid, ex_RegWrite, ex_MemRead, stall); end
        mem_RegWrite = 1; mem_rdAddr = 5'd4; mem_ALUResult = 32'h104;
        tick();
        mem_RegWrite = 0; wb_RegWrite = 1; wb_rdAddr = 5'd4; wb_Data = 32'hCAFE;
        #1;
        total++; if (A !== 32'hCAFE || B !== 32'h100 || ex_valid !== 1'b1 || ex_rdAddr !== 5'd5)
            begin bad++; $display("FAIL lu_resume got=%h/%h v%b rd%0d exp=cafe/100 v1 rd5", A, B, ex_valid, ex_rdAddr); end
        clr_in();
        tick();
        // x4 named only through unused fields: PC/imm sources, no store
        set_id(4'h0, 2'b00, 1'b1, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h4, 32'h200, 1, 1, 0);
        tick();
        set_id(4'h0, 2'b01, 1'b1, 5'd4, 5'd4, 5'd5, 32'h0, 32'h0, 32'h10, 32'h204, 1, 0, 0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_nouse got=%b exp=0", stall); end
        // store of x4 uses rs2 even with immediate B
        id_ALUSrcA = 2'b00; id_rs1Addr = 5'd1; id_MemWrite = 1; id_RegWrite = 0;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_store got=%b exp=1", stall); end
        id_valid = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_idinv got=%b exp=0", stall); end
        clr_in();
        tick();
        // load into x0 never stalls
        set_id(4'h0, 2'b00, 1'b1, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 32'h200, 1, 1, 0);
        tick();
        set_id(4'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 32'h204, 1, 0, 0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_x0 got=%b exp=0", stall); end
        clr_in();
        tick();
    endtask

    task automatic test_flush();
        set_id(4'h0, 2'b00, 1'b1, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h4, 32'h200, 1, 1, 0);
        tick();
        // sw x4, 0(x1) stalls; flush in the same cycle
        set_id(4'h0, 2'b00, 1'b1, 5'd1, 5'd4, 5'd0, 32'h100, 32'h9, 32'h0, 32'h204, 0, 0, 1);
        flush = 1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fl_pre got=%b exp=1", stall); end
        tick();
        total++; if (ex_RegWrite !== 1'b0 || ex_MemWrite !== 1'b0 || ex_valid !== 1'b0 || stall !== 1'b0)
            begin bad++; $display("FAIL fl_bubble got=rw%b mw%b v%b st%b exp=0000", ex_RegWrite, ex_MemWrite, ex_valid, stall); end
        // flush alone kills a store with no hazard
        tick();
        total++; if (ex_MemWrite !== 1'b0 || ex_valid !== 1'b0 || A !== 32'h0)
            begin bad++; $display("FAIL fl_alone got=mw%b v%b A%h exp=0 0 0", ex_MemWrite, ex_valid, A); end
        clr_in();
        tick();
    endtask

    task automatic test_write_through();
        wb_RegWrite = 1; wb_rdAddr = 5'd6; wb_Data = 32'hDEAD;
        set_id(4'h0, 2'b00, 1'b0, 5'd6, 5'd6, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        tick();
        wb_RegWrite = 0;
        #1;
        total++; if (A !== 32'hDEAD || B !== 32'hDEAD)
            begin bad++; $display("FAIL wt_x6 got=%h/%h exp=dead/dead", A, B); end
        // only the matching operand is patched
        wb_RegWrite = 1; wb_rdAddr = 5'd6; wb_Data = 32'hBEEF;
        set_id(4'h0, 2'b00, 1'b0, 5'd2, 5'd6, 5'd7, 32'h12, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        tick();
        wb_RegWrite = 0;
        #1;
        total++; if (A !== 32'h12 || B !== 32'hBEEF)
            begin bad++; $display("FAIL wt_rs2 got=%h/%h exp=12/beef", A, B); end
        wb_RegWrite = 1; wb_rdAddr = 5'd0; wb_Data = 32'h99;
        set_id(4'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd7, 32'h55, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        tick();
        wb_RegWrite = 0;
        #1;
        total++; if (A !== 32'h55) begin bad++; $display("FAIL wt_x0 got=%h exp=55", A); end
        clr_in();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        set_id(4'h0, 2'b00, 1'b1, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h4, 32'h200, 1, 1, 0);
        tick();
        set_id(4'h0, 2'b00, 1'b0, 5'd4, 5'd1, 5'd5, 32'h0, 32'h100, 32'h0, 32'h204, 1, 0, 0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_pre got=%b exp=1", stall); end
        reset = 1;
        tick();
        total++; if (ex_valid !== 1'b0 || ex_MemRead !== 1'b0 || ex_rdAddr !== 5'd0 || stall !== 1'b0)
            begin bad++; $display("FAIL rms_clear got=v%b mr%b rd%0d st%b exp=0 0 0 0", ex_valid, ex_MemRead, ex_rdAddr, stall); end
        reset = 0;
        tick();
        total++; if (ex_valid !== 1'b1 || ex_rdAddr !== 5'd5 || A !== 32'h0)
            begin bad++; $display("FAIL rms_after got=v%b rd%0d A%h exp=1 5 0", ex_valid, ex_rdAddr, A); end
        clr_in();
        tick();
    endtask

    initial begin
        reset = 1;
        clr_in();
        test_reset();
        test_pass_through();
        test_forwarding();
        test_load_use();
        test_flush();
        test_write_through();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
